// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int BAUD_CNT_W = 14;

    // 9600 baud at 100 MHz. The receiver derives its mid-bit point from this same value.
    localparam logic [BAUD_CNT_W-1:0] CLKS_PER_BIT_9600 = 14'd10417;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between an upstream producer and the UART transmitter.
// valid/ready: a byte moves on a rising clock edge where valid && ready are both 1.
// The producer holds valid and data steady until that edge; ready never depends on valid.
interface uart_tx_if;
    import uart_pkg::*;

    logic                 valid;
    logic [DATA_BITS-1:0] data;
    logic                 ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/uart_tx_baud_counter.sv
// Bit-period timer: loads on request, counts down while enabled and
// flags the last cycle of each bit period, reloading itself on that cycle.
module baud_counter #(
    parameter int WIDTH        = 14,
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic load,
    input  logic enable,
    output logic done
);

    localparam logic [WIDTH-1:0] RELOAD = WIDTH'(CLKS_PER_BIT - 1);

    logic [WIDTH-1:0] count;

    assign done = enable && (count == '0);

    // Count down one bit period; done marks the final cycle so the next period starts seamlessly.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (enable) begin
            count <= done ? RELOAD : (count - 1'b1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1, LSB first. Line idles high; every output comes from a flop.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = int'(CLKS_PER_BIT_9600)
) (
    input  logic   clk_i,
    input  logic   reset_i,
    uart_tx_if.slave bus,
    output logic   tx_o,
    output logic   busy_o,
    output state_e dbg_state
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    state_e               state, state_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [2:0]           bit_cnt, bit_n;
    logic                 tx_q, tx_n;
    logic                 ready_q, ready_n;
    logic                 busy_q, busy_n;
    logic                 load;
    logic                 bit_done;
    logic                 transfer;

    assign transfer  = bus.valid && ready_q;
    assign bus.ready = ready_q;
    assign tx_o      = tx_q;
    assign busy_o    = busy_q;
    assign dbg_state = state;

    baud_counter #(
        .WIDTH        (BAUD_CNT_W),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load    (load),
        .enable  (state != IDLE),
        .done    (bit_done)
    );

    // Register state and all line-facing outputs; reset forces the line high immediately.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_n;
            shift   <= shift_n;
            bit_cnt <= bit_n;
            tx_q    <= tx_n;
            ready_q <= ready_n;
            busy_q  <= busy_n;
        end
    end

    // Next-state and next-output logic; tx_n is the value the line takes for the following bit.
    always_comb begin
        state_n = state;
        shift_n = shift;
        bit_n   = bit_cnt;
        tx_n    = tx_q;
        ready_n = ready_q;
        busy_n  = busy_q;
        load    = 1'b0;
        case (state)
            IDLE: begin
                tx_n    = 1'b1;
                ready_n = 1'b1;
                busy_n  = 1'b0;
                if (transfer) begin
                    state_n = START;
                    shift_n = bus.data;
                    load    = 1'b1;
                    tx_n    = 1'b0;
                    ready_n = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            START: begin
                if (bit_done) begin
                    state_n = DATA;
                    tx_n    = shift[0];
                    bit_n   = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_n = {1'b0, shift[DATA_BITS-1:1]};
                    bit_n   = bit_cnt + 3'd1;
                    if (bit_cnt == LAST_BIT) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        tx_n = shift[1];
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_n = IDLE;
                    ready_n = 1'b1;
                    busy_n  = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
                ready_n = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at 16 clocks per bit with a serial-line decoder.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int N        = 16;
    localparam int RX_WAIT  = 400;
    localparam int RDY_WAIT = 20 * N;

    logic   clk_i = 1'b0;
    logic   reset_i = 1'b1;
    logic   tx_o;
    logic   busy_o;
    state_e dbg_state;
    int     cyc = 0;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [7:0] exp_q[$];

    uart_tx_if bus ();

    uart_tx #(.CLKS_PER_BIT(N)) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .bus       (bus),
        .tx_o      (tx_o),
        .busy_o    (busy_o),
        .dbg_state (dbg_state)
    );

    // Clock and cycle count.
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Global time limit.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", vec_cnt, err_cnt);
        $fatal(1, "watchdog");
    end

    // Offer one byte, wait for ready, complete the handshake, record the byte as expected.
    // Returns 1 time unit after the transfer edge; hold keeps valid high afterwards.
    task automatic drive_byte(input logic [7:0] b, input logic hold);
        int waited;
        waited = 0;
        bus.valid = 1'b1;
        bus.data  = b;
        while (bus.ready !== 1'b1 && waited < RDY_WAIT) begin
            @(negedge clk_i);
            waited++;
        end
        if (bus.ready !== 1'b1) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL drive_ready_timeout: ready=%b after %0d cycles, required 1", bus.ready, waited);
            bus.valid = 1'b0;
        end else begin
            @(posedge clk_i);
            #1;
            exp_q.push_back(b);
            if (!hold) bus.valid = 1'b0;
        end
    endtask

    // Decode one frame from the line, sampling each bit in its middle.
    task automatic rx_frame(output logic [7:0] b, output logic stop_bit, output int start_cyc, output bit ok);
        int w;
        w = 0;
        b = '0;
        stop_bit = 1'b0;
        start_cyc = 0;
        ok = 1'b0;
        @(negedge clk_i);
        while (tx_o !== 1'b0 && w < RX_WAIT) begin
            @(negedge clk_i);
            w++;
        end
        if (tx_o !== 1'b0) return;
        start_cyc = cyc;
        repeat (N / 2) @(negedge clk_i);
        if (tx_o !== 1'b0) return;
        for (int k = 0; k < 8; k++) begin
            repeat (N) @(negedge clk_i);
            b[k] = tx_o;
        end
        repeat (N) @(negedge clk_i);
        stop_bit = tx_o;
        ok = 1'b1;
    endtask

    // Compare a decoded frame against the head of the expected queue.
    task automatic score_frame(input string name, input logic [7:0] got, input logic stop_bit, input bit ok);
        logic [7:0] exp_b;
        vec_cnt++;
        if (!ok) begin
            err_cnt++;
            $display("FAIL %s_frame: no complete frame seen on line, required a frame", name);
            return;
        end
        if (exp_q.size() == 0) begin
            err_cnt++;
            $display("FAIL %s_extra: got byte %h, required no frame", name, got);
            return;
        end
        exp_b = exp_q.pop_front();
        if (got !== exp_b) begin
            err_cnt++;
            $display("FAIL %s_data: got %h, required %h", name, got, exp_b);
        end
        vec_cnt++;
        if (stop_bit !== 1'b1) begin
            err_cnt++;
            $display("FAIL %s_stop: stop bit %b, required 1", name, stop_bit);
        end
    endtask

    // Watch the line for a number of cycles and report any low level (a frame that should not exist).
    task automatic expect_idle(input string name, input int cycles);
        int lows;
        lows = 0;
        repeat (cycles) begin
            @(negedge clk_i);
            if (tx_o !== 1'b1) lows++;
        end
        vec_cnt++;
        if (lows != 0 || bus.ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL %s_idle: %0d non-idle line cycles, ready=%b, required 0 and ready=1", name, lows, bus.ready);
        end
    endtask

    task automatic test_reset();
        bus.valid = 1'b0;
        bus.data  = '0;
        reset_i   = 1'b1;
        repeat (5) @(posedge clk_i);
        #1;
        vec_cnt++;
        if (tx_o !== 1'b1 || bus.ready !== 1'b1 || busy_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_outputs: tx=%b ready=%b busy=%b, required 1 1 0", tx_o, bus.ready, busy_o);
        end
        vec_cnt++;
        if (dbg_state !== IDLE) begin
            err_cnt++;
            $display("FAIL reset_state: state=%0d, required %0d", dbg_state, IDLE);
        end
        @(negedge clk_i);
        reset_i = 1'b0;
        repeat (3) @(negedge clk_i);
        vec_cnt++;
        if (tx_o !== 1'b1 || bus.ready !== 1'b1 || busy_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL post_reset_idle: tx=%b ready=%b busy=%b, required 1 1 0", tx_o, bus.ready, busy_o);
        end
    endtask

    // Cycle-exact waveform of 0x55: ten bits of 16 cycles, ready back after 160 cycles.
    task automatic test_single_55();
        logic [9:0] frame;
        logic [7:0] got;
        logic [7:0] exp_b;
        logic       a_tx, a_rdy, a_busy;
        bit         bad;
        frame = {1'b1, 8'h55, 1'b0};
        got   = '0;
        @(negedge clk_i);
        drive_byte(8'h55, 1'b0);
        for (int bi = 0; bi < 10; bi++) begin
            bad = 1'b0;
            a_tx = 1'b0; a_rdy = 1'b0; a_busy = 1'b0;
            for (int c = 0; c < N; c++) begin
                if (!bad && (tx_o !== frame[bi] || bus.ready !== 1'b0 || busy_o !== 1'b1)) begin
                    bad = 1'b1;
                    a_tx = tx_o; a_rdy = bus.ready; a_busy = busy_o;
                end
                if (bi >= 1 && bi <= 8 && c == N / 2) got[bi-1] = tx_o;
                @(posedge clk_i);
                #1;
            end
            vec_cnt++;
            if (bad) begin
                err_cnt++;
                $display("FAIL single55_bit%0d: tx=%b ready=%b busy=%b, required tx=%b ready=0 busy=1", bi, a_tx, a_rdy, a_busy, frame[bi]);
            end
        end
        vec_cnt++;
        if (bus.ready !== 1'b1 || busy_o !== 1'b0 || tx_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL single55_end: ready=%b busy=%b tx=%b 160 cycles after start bit, required 1 0 1", bus.ready, busy_o, tx_o);
        end
        vec_cnt++;
        if (exp_q.size() == 0) begin
            err_cnt++;
            $display("FAIL single55_queue: scoreboard empty, required one byte");
        end else begin
            exp_b = exp_q.pop_front();
            if (got !== exp_b) begin
                err_cnt++;
                $display("FAIL single55_data: decoded %h, required %h", got, exp_b);
            end
        end
    endtask

    // 0x00 then 0xFF with valid held: stop bit intact, next start one idle cycle after it.
    task automatic test_back_to_back();
        logic [7:0] b1, b2;
        logic       s1, s2;
        int         c1, c2;
        bit         ok1, ok2;
        @(negedge clk_i);
        fork
            begin
                drive_byte(8'h00, 1'b1);
                drive_byte(8'hFF, 1'b0);
            end
            begin
                rx_frame(b1, s1, c1, ok1);
                rx_frame(b2, s2, c2, ok2);
            end
        join
        score_frame("b2b_first", b1, s1, ok1);
        score_frame("b2b_second", b2, s2, ok2);
        vec_cnt++;
        if (c2 - c1 !== 10 * N + 1) begin
            err_cnt++;
            $display("FAIL b2b_spacing: start-to-start %0d cycles, required %0d", c2 - c1, 10 * N + 1);
        end
        expect_idle("b2b", 12 * N);
    endtask

    // A valid pulse while a frame is in flight must not be taken or disturb the frame.
    task automatic test_ignore_busy();
        logic [7:0] b;
        logic       s;
        int         c;
        bit         ok;
        @(negedge clk_i);
        fork
            begin
                drive_byte(8'hA3, 1'b0);
                repeat (35) @(negedge clk_i);
                vec_cnt++;
                if (bus.ready !== 1'b0 || busy_o !== 1'b1) begin
                    err_cnt++;
                    $display("FAIL busy_flags: ready=%b busy=%b mid-frame, required 0 1", bus.ready, busy_o);
                end
                bus.valid = 1'b1;
                bus.data  = 8'h12;
                @(negedge clk_i);
                bus.valid = 1'b0;
            end
            begin
                rx_frame(b, s, c, ok);
            end
        join
        score_frame("busy_pulse", b, s, ok);
        expect_idle("busy_pulse", 20 * N);
    endtask

    // Asynchronous reset during the data bits of 0x00 pulls the line high with no clock edge.
    task automatic test_reset_mid_frame();
        logic [7:0] b;
        logic       s;
        int         c;
        bit         ok;
        @(negedge clk_i);
        drive_byte(8'h00, 1'b0);
        repeat (3 * N) @(posedge clk_i);
        #3;
        vec_cnt++;
        if (tx_o !== 1'b0 || dbg_state !== DATA) begin
            err_cnt++;
            $display("FAIL midframe_pre: tx=%b state=%0d, required 0 and %0d", tx_o, dbg_state, DATA);
        end
        reset_i = 1'b1;
        #1;
        vec_cnt++;
        if (tx_o !== 1'b1 || bus.ready !== 1'b1 || busy_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL midframe_async: tx=%b ready=%b busy=%b, required 1 1 0", tx_o, bus.ready, busy_o);
        end
        exp_q.delete();
        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;
        repeat (2) @(negedge clk_i);
        vec_cnt++;
        if (dbg_state !== IDLE || bus.ready !== 1'b1 || tx_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL midframe_recover: state=%0d ready=%b tx=%b, required %0d 1 1", dbg_state, bus.ready, tx_o, IDLE);
        end
        fork
            drive_byte(8'h3C, 1'b0);
            rx_frame(b, s, c, ok);
        join
        score_frame("after_reset", b, s, ok);
    endtask

    // 200 random bytes with random gaps; every byte arrives once and in order.
    task automatic test_random();
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    repeat ($urandom_range(0, 40)) @(negedge clk_i);
                    drive_byte(8'($urandom_range(0, 255)), 1'b0);
                end
            end
            begin
                logic [7:0] b;
                logic       s;
                int         c;
                bit         ok;
                for (int i = 0; i < 200; i++) begin
                    rx_frame(b, s, c, ok);
                    score_frame("random", b, s, ok);
                end
            end
        join
        vec_cnt++;
        if (exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL random_leftover: %0d bytes never seen on line, required 0", exp_q.size());
        end
    endtask

    initial begin
        bus.valid = 1'b0;
        bus.data  = '0;
        test_reset();
        test_single_55();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
